// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: shared definitions for the USB transmit path.
//   - tx_state_e : NRZI encoder state machine encoding
//   - J_DP/J_DM, K_DP/K_DM : line levels for the J and K bus states
//   - line_dp/line_dm : map a J/K line state to D+/D- levels
// Polarity macro: USB_TX_LOW_SPEED_EN selects low-speed polarity (J = dp 0 / dm 1);
// when undefined, full-speed polarity is used (J = dp 1 / dm 0).
package usb_tx_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StData   = 2'd1,
      StEopSe0 = 2'd2,
      StEopJ   = 2'd3
   } tx_state_e;

`ifdef USB_TX_LOW_SPEED_EN
   localparam logic J_DP = 1'b0;
   localparam logic J_DM = 1'b1;
   localparam logic K_DP = 1'b1;
   localparam logic K_DM = 1'b0;
`else
   localparam logic J_DP = 1'b1;
   localparam logic J_DM = 1'b0;
   localparam logic K_DP = 1'b0;
   localparam logic K_DM = 1'b1;
`endif

   // is_k = 1 selects the K state, 0 selects J
   function automatic logic line_dp(input logic is_k);
      return is_k ? K_DP : J_DP;
   endfunction

   function automatic logic line_dm(input logic is_k);
      return is_k ? K_DM : J_DM;
   endfunction

endpackage

// File: rtl/nrzi_encoder.sv
// nrzi_encoder: NRZI line encoder and EOP generator for the USB transmit path.
// Consumes one stuffed bit per bit_strobe, drives D+/D- with NRZI encoding, and
// terminates each packet with EOP_SE0_BITS bit periods of SE0 followed by one J.
// Ports:
//   clk          in   system clock, rising edge
//   n_rst        in   asynchronous active-low reset
//   bit_strobe   in   one-cycle pulse per USB bit period
//   tx_bit       in   stuffed serial data bit
//   tx_bit_valid in   tx_bit holds a bit to transmit
//   eop_req      in   packet ends after the last valid bit
//   bit_ready    out  combinational; tx_bit consumed this cycle
//   dp, dm       out  registered D+/D- line levels
//   tx_active    out  registered transceiver output enable
//   eop_done     out  registered one-cycle pulse when EOP completes
//   underrun_err out  registered one-cycle pulse on data starvation
// Parameter: EOP_SE0_BITS (1-4), SE0 length in bit periods.
// Polarity macro: USB_TX_LOW_SPEED_EN (see usb_tx_pkg).
module nrzi_encoder
   import usb_tx_pkg::*;
#(
   parameter int unsigned EOP_SE0_BITS = 2
) (
   input  logic clk,
   input  logic n_rst,
   input  logic bit_strobe,
   input  logic tx_bit,
   input  logic tx_bit_valid,
   input  logic eop_req,
   output logic bit_ready,
   output logic dp,
   output logic dm,
   output logic tx_active,
   output logic eop_done,
   output logic underrun_err
);

   // Counter value on the strobe that ends the SE0 phase
   localparam logic [1:0] SE0_LAST = 2'(EOP_SE0_BITS - 1);

   tx_state_e  state_q, state_d;
   logic       line_k_q, line_k_d;   // current NRZI line state, 1 = K
   logic [1:0] cnt_q, cnt_d;
   logic       dp_q, dp_d;
   logic       dm_q, dm_d;
   logic       active_q, active_d;
   logic       done_q, done_d;
   logic       urun_q, urun_d;
   logic       can_accept;

   assign can_accept = (state_q == StIdle) || (state_q == StData);
   assign bit_ready  = bit_strobe & tx_bit_valid & can_accept;

   always_comb begin
      state_d  = state_q;
      line_k_d = line_k_q;
      cnt_d    = cnt_q;
      dp_d     = dp_q;
      dm_d     = dm_q;
      active_d = active_q;
      done_d   = 1'b0;
      urun_d   = 1'b0;

      if (bit_strobe) begin
         unique case (state_q)
            StIdle: begin
               // eop_req is meaningless here; only a valid bit starts a packet
               if (tx_bit_valid) begin
                  state_d  = StData;
                  active_d = 1'b1;
                  line_k_d = ~tx_bit;  // line rests at J, a 0 toggles to K
                  dp_d     = line_dp(line_k_d);
                  dm_d     = line_dm(line_k_d);
               end
            end
            StData: begin
               if (tx_bit_valid) begin
                  // Data wins over a simultaneous eop_req; EOP follows on a later strobe
                  line_k_d = line_k_q ^ ~tx_bit;
                  dp_d     = line_dp(line_k_d);
                  dm_d     = line_dm(line_k_d);
               end else begin
                  // Starvation without eop_req still closes the packet cleanly
                  state_d = StEopSe0;
                  dp_d    = 1'b0;
                  dm_d    = 1'b0;
                  cnt_d   = 2'd0;
                  urun_d  = ~eop_req;
               end
            end
            StEopSe0: begin
               if (cnt_q == SE0_LAST) begin
                  state_d  = StEopJ;
                  line_k_d = 1'b0;
                  dp_d     = J_DP;
                  dm_d     = J_DM;
               end else begin
                  cnt_d = cnt_q + 2'd1;
               end
            end
            StEopJ: begin
               state_d  = StIdle;
               active_d = 1'b0;
               done_d   = 1'b1;
               line_k_d = 1'b0;
               dp_d     = J_DP;
               dm_d     = J_DM;
            end
            default: begin
               state_d  = StIdle;
               active_d = 1'b0;
               line_k_d = 1'b0;
               dp_d     = J_DP;
               dm_d     = J_DM;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q  <= StIdle;
         line_k_q <= 1'b0;
         cnt_q    <= 2'd0;
         dp_q     <= J_DP;
         dm_q     <= J_DM;
         active_q <= 1'b0;
         done_q   <= 1'b0;
         urun_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         line_k_q <= line_k_d;
         cnt_q    <= cnt_d;
         dp_q     <= dp_d;
         dm_q     <= dm_d;
         active_q <= active_d;
         done_q   <= done_d;
         urun_q   <= urun_d;
      end
   end

   assign dp           = dp_q;
   assign dm           = dm_q;
   assign tx_active    = active_q;
   assign eop_done     = done_q;
   assign underrun_err = urun_q;

endmodule
